tick_gen: RTL and testbench
===========================

// Module: tick_gen
// PURPOSE
//  Multi-channel programmable tick generator; successor to the single free-running divider.
//  Each channel emits a one-cycle tick every (div+1) clocks and a derived square wave.
//  Sits at the top level and feeds game-generation step, display refresh and key-scan
//  timing from one clock domain. Keeps a free-running counter output for existing users.
// PARAMETERS
//  NCH        4   number of independent channels (1..16)
//  WIDTH      32  counter / divider width in bits
//  RESET_DIV  0   per-channel divider value loaded at reset (period = RESET_DIV+1)
//  CH_W       derived = max(1,$clog2(NCH)); not overridden
// PORTS
//  clk       in   1          system clock; single clock domain
//  rst       in   1          asynchronous, active-high reset
//  en        in   NCH        per-channel run enable
//  sync      in   1          synchronous clear of all channel counters (phase align)
//  div_wr    in   1          divider write strobe, one cycle
//  div_sel   in   CH_W       channel addressed by div_wr
//  div_val   in   WIDTH      new divider value; period = div_val+1 clocks
//  div_pend  out  NCH        write captured, not yet applied
//  div_ack   out  NCH        one-cycle pulse: pending divider has just been applied
//  tick      out  NCH        one-cycle pulse on terminal count
//  half      out  NCH        toggles on every tick (data signal, never used as a clock)
//  free_cnt  out  WIDTH      free-running up counter, wraps 2^WIDTH-1 -> 0
// BEHAVIOUR
//  - Reset (async assert, sync release): cnt=0, div=RESET_DIV, div_pend=0, div_ack=0,
//    tick=0, half=0, free_cnt=0. Reset mid-operation discards pending writes silently.
//  - free_cnt increments every cycle regardless of en/sync; wraps modulo 2^WIDTH.
//  - Per channel i, priority order: sync > terminal count > count > hold.
//    en[i]=1, cnt==div: cnt<=0, tick[i]<=1 (next cycle), half[i] toggles.
//    en[i]=1, cnt!=div: cnt<=cnt+1, tick[i]<=0.  en[i]=0: cnt holds, tick[i]<=0, half holds.
//  - tick is registered: asserted the cycle after cnt==div. div=0 -> tick every cycle;
//    half then toggles every cycle.
//  - Write: div_wr with div_sel<NCH loads pend_val[sel], sets div_pend[sel] next cycle.
//    div_sel>=NCH: ignored, no pend, no ack. Second write before apply overwrites
//    pend_val; exactly one ack for the value finally applied.
//  - Apply: pending value moves to div on the first terminal count strictly after the
//    write cycle, or on sync, or on any cycle with en[i]=0. Same edge clears div_pend[i];
//    div_ack[i] pulses the following cycle. Glitch-free: a running period never truncates.
//  - Write in the same cycle as the apply edge: new value stays pending (not applied).
//  - sync: all cnt<=0, half<=0, tick<=0; pending values applied. sync + terminal count in
//    one cycle: sync wins, no tick.
//  - Arithmetic: cnt compare is unsigned equality; cnt never exceeds div because div only
//    changes when cnt is 0-bound (terminal/sync) or channel is idle; on idle apply with
//    cnt>div, cnt<=0.
// STRUCTURE
//  - Shared defines header: CH_W computation macro, per-design default divider constants
//    (generation step, refresh, key scan) used at instantiation.
//  - One sub-module tick_chan (cnt, div, pend_val, tick, half, ack for one channel),
//    instantiated NCH times via generate; tick_gen holds write decode and free_cnt.
// TESTING
//  1 rst=1 then release, en=0 -> all outputs 0, free_cnt counts 0,1,2.. from release.
//  2 NCH=4, RESET_DIV=0, en=4'b0001 -> tick[0] every cycle, half[0] alternates 0/1.
//  3 write ch1 div_val=4, en[1]=1 -> ack[1] after current period; then tick[1] every
//    5 cycles, half[1] period 10 cycles.
//  4 ch2 running div=9, write 2 at cnt=3 -> div_pend[2]=1, ticks at cnt 9, ack next
//    cycle, following ticks spaced 3 cycles; write div_sel=5 -> no pend, no ack.
//  5 two channels div=3 and 6 out of phase, pulse sync -> both cnt 0, half 0,
//    next ticks 4 and 7 cycles after sync; sync on terminal cycle suppresses tick.
//  6 WIDTH=4 free_cnt 15->0 wrap; assert rst mid-period with pending write -> pend
//    and ack cleared, div back to RESET_DIV.

Source files
------------

// File: rtl/tick_gen_pkg.sv
// Shared definitions for the tick generator: select-width helper, channel action
// encoding and default divider values for the game-step, refresh and key-scan channels.
package tick_gen_pkg;

    typedef enum logic [1:0] {
        ACT_HOLD  = 2'd0,
        ACT_COUNT = 2'd1,
        ACT_TERM  = 2'd2,
        ACT_SYNC  = 2'd3
    } chan_act_e;

    // Divider defaults for a 50 MHz system clock (period = value + 1 clocks).
    localparam logic [31:0] GEN_STEP_DIV = 32'd24_999_999;
    localparam logic [31:0] REFRESH_DIV  = 32'd49_999;
    localparam logic [31:0] KEY_SCAN_DIV = 32'd249_999;

    function automatic int ch_w(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/tick_gen_chan.sv
// One tick channel: programmable period counter with a glitch-free pending-divider
// update, registered tick pulse, derived half-rate square wave and apply acknowledge.
module tick_gen_chan
    import tick_gen_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_DIV = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_val,
    output logic             pend,
    output logic             ack,
    output logic             tick,
    output logic             half
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] pval_q, pval_d;
    logic             pend_q, pend_d;
    logic             ack_q, ack_d;
    logic             tick_q, tick_d;
    logic             half_q, half_d;
    logic             apply;
    chan_act_e        act;

    always_comb begin
        act = ACT_HOLD;
        if (sync) begin
            act = ACT_SYNC;
        end else if (en && (cnt_q == div_q)) begin
            act = ACT_TERM;
        end else if (en) begin
            act = ACT_COUNT;
        end

        // Only period boundaries, sync or an idle channel may take a new divider,
        // so a running period is never cut short.
        apply  = pend_q && ((act == ACT_SYNC) || (act == ACT_TERM) || !en);
        div_d  = apply ? pval_q : div_q;
        pend_d = wr ? 1'b1 : (apply ? 1'b0 : pend_q);
        pval_d = wr ? wr_val : pval_q;
        ack_d  = apply;

        cnt_d  = cnt_q;
        tick_d = 1'b0;
        half_d = half_q;
        case (act)
            ACT_SYNC: begin
                cnt_d  = '0;
                half_d = 1'b0;
            end
            ACT_TERM: begin
                cnt_d  = '0;
                tick_d = 1'b1;
                half_d = ~half_q;
            end
            ACT_COUNT: cnt_d = cnt_q + WIDTH'(1);
            default: begin
                if (apply && (cnt_q > pval_q)) begin
                    cnt_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            div_q  <= RESET_DIV;
            pval_q <= '0;
            pend_q <= 1'b0;
            ack_q  <= 1'b0;
            tick_q <= 1'b0;
            half_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            pval_q <= pval_d;
            pend_q <= pend_d;
            ack_q  <= ack_d;
            tick_q <= tick_d;
            half_q <= half_d;
        end
    end

    assign pend = pend_q;
    assign ack  = ack_q;
    assign tick = tick_q;
    assign half = half_q;

endmodule

// File: rtl/tick_gen.sv
// Multi-channel programmable tick generator: divider write decode, NCH tick channels
// and the legacy free-running counter, all in one clock domain.
module tick_gen
    import tick_gen_pkg::*;
#(
    parameter int               NCH       = 4,
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_DIV = '0,
    parameter int               CH_W      = ch_w(NCH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   en,
    input  logic             sync,
    input  logic             div_wr,
    input  logic [CH_W-1:0]  div_sel,
    input  logic [WIDTH-1:0] div_val,
    output logic [NCH-1:0]   div_pend,
    output logic [NCH-1:0]   div_ack,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   half,
    output logic [WIDTH-1:0] free_cnt
);

    logic [WIDTH-1:0] free_q, free_d;
    logic [NCH-1:0]   wr_hit;

    assign free_d = free_q + WIDTH'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            free_q <= '0;
        end else begin
            free_q <= free_d;
        end
    end

    assign free_cnt = free_q;

    // Selects at or beyond NCH match no channel and are dropped.
    for (genvar i = 0; i < NCH; i++) begin : g_chan
        assign wr_hit[i] = div_wr && (div_sel == CH_W'(i));

        tick_gen_chan #(
            .WIDTH     (WIDTH),
            .RESET_DIV (RESET_DIV)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .en     (en[i]),
            .sync   (sync),
            .wr     (wr_hit[i]),
            .wr_val (div_val),
            .pend   (div_pend[i]),
            .ack    (div_ack[i]),
            .tick   (tick[i]),
            .half   (half[i])
        );
    end

endmodule

// File: tb/tb_tick_gen.sv
// Bench for tick_gen: cycle-level reference model compared every clock plus directed
// scenarios with hand-computed tick spacings, acknowledge timing and reset behaviour.
module tb_tick_gen;

    localparam int NCH   = 5;
    localparam int WIDTH = 4;
    localparam int CH_W  = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NCH-1:0]   en = '0;
    logic             sync = 1'b0;
    logic             div_wr = 1'b0;
    logic [CH_W-1:0]  div_sel = '0;
    logic [WIDTH-1:0] div_val = '0;
    logic [NCH-1:0]   div_pend, div_ack, tick, half;
    logic [WIDTH-1:0] free_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    tick_gen #(
        .NCH       (NCH),
        .WIDTH     (WIDTH),
        .RESET_DIV (4'd0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sync     (sync),
        .div_wr   (div_wr),
        .div_sel  (div_sel),
        .div_val  (div_val),
        .div_pend (div_pend),
        .div_ack  (div_ack),
        .tick     (tick),
        .half     (half),
        .free_cnt (free_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: per channel, position within the current period, active period
    // length, and a mailbox holding the most recent unapplied divider write.
    int             m_pos   [NCH];
    int             m_div   [NCH];
    int             m_mail  [NCH];
    logic [NCH-1:0] m_full, m_tick, m_half, m_ack;
    int             m_free;
    bit             hit, boundary, swap;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                m_pos[i]  = 0;
                m_div[i]  = 0;
                m_mail[i] = 0;
            end
            m_full = '0;
            m_tick = '0;
            m_half = '0;
            m_ack  = '0;
            m_free = 0;
        end else begin
            m_free = (m_free + 1) % (1 << WIDTH);
            for (int i = 0; i < NCH; i++) begin
                hit      = div_wr && (int'(div_sel) == i);
                boundary = en[i] && (m_pos[i] == m_div[i]);
                swap     = m_full[i] && (sync || !en[i] || boundary);
                m_ack[i]  = swap;
                m_tick[i] = 1'b0;
                if (swap) m_div[i] = m_mail[i];
                if (sync) begin
                    m_pos[i]  = 0;
                    m_half[i] = 1'b0;
                end else if (boundary) begin
                    m_pos[i]  = 0;
                    m_tick[i] = 1'b1;
                    m_half[i] = !m_half[i];
                end else if (en[i]) begin
                    m_pos[i] = m_pos[i] + 1;
                end else if (m_pos[i] > m_div[i]) begin
                    m_pos[i] = 0;
                end
                if (hit) begin
                    m_mail[i] = int'(div_val);
                    m_full[i] = 1'b1;
                end else if (swap) begin
                    m_full[i] = 1'b0;
                end
            end
        end
        #1;
        check("model_tick", int'(tick), int'(m_tick));
        check("model_half", int'(half), int'(m_half));
        check("model_pend", int'(div_pend), int'(m_full));
        check("model_ack", int'(div_ack), int'(m_ack));
        check("model_free", int'(free_cnt), m_free);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_tick(input int ch, input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick[ch] && n < budget);
        if (!tick[ch]) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_tick ch%0d: no tick within %0d cycles", ch, budget);
            n = -1;
        end
    endtask

    task automatic write_div(input int sel, input int val);
        div_wr  = 1'b1;
        div_sel = CH_W'(sel);
        div_val = WIDTH'(val);
        @(negedge clk);
        div_wr  = 1'b0;
    endtask

    initial begin
        int n, t3, t4;
        logic h;

        // 1: reset and release with all channels idle
        step(3);
        check("t1_rst_free", int'(free_cnt), 0);
        check("t1_rst_tick", int'(tick), 0);
        rst = 1'b0;
        check("t1_rel_free0", int'(free_cnt), 0);
        step(1);
        check("t1_free1", int'(free_cnt), 1);
        step(1);
        check("t1_free2", int'(free_cnt), 2);
        check("t1_idle_out", int'({div_pend, div_ack, tick, half}), 0);

        // 2: channel 0 at reset divider 0 ticks every cycle
        en = 5'b00001;
        wait_tick(0, 4, n);
        check("t2_first_tick", n, 1);
        h = half[0];
        step(1);
        check("t2_tick_again", int'(tick[0]), 1);
        check("t2_half_alt1", int'(half[0]), int'(!h));
        step(1);
        check("t2_half_alt2", int'(half[0]), int'(h));

        // 3: program channel 1 to period 5 while enabling it
        en = 5'b00011;
        write_div(1, 4);
        check("t3_pend", int'(div_pend[1]), 1);
        step(1);
        check("t3_ack", int'(div_ack[1]), 1);
        check("t3_pend_clr", int'(div_pend[1]), 0);
        wait_tick(1, 8, n);
        check("t3_space1", n, 5);
        wait_tick(1, 8, n);
        check("t3_space2", n, 5);

        // 4: channel 2 at div 9, rewritten to 2 mid-period
        write_div(2, 9);
        step(1);
        check("t4_idle_ack", int'(div_ack[2]), 1);
        en[2] = 1'b1;
        step(3);
        write_div(2, 2);
        check("t4_pend", int'(div_pend[2]), 1);
        wait_tick(2, 12, n);
        check("t4_tick_at9", n, 6);
        check("t4_ack", int'(div_ack[2]), 1);
        check("t4_pend_clr", int'(div_pend[2]), 0);
        wait_tick(2, 8, n);
        check("t4_space3", n, 3);
        write_div(5, 7);
        check("t4_bad_sel_pend", int'(div_pend), 0);
        step(2);
        check("t4_bad_sel_ack", int'(div_ack), 0);

        // 5: sync aligns channels 3 (div 3) and 4 (div 6)
        write_div(3, 3);
        write_div(4, 6);
        step(1);
        en[3] = 1'b1;
        step(2);
        en[4] = 1'b1;
        step(3);
        sync = 1'b1;
        step(1);
        sync = 1'b0;
        check("t5_half3", int'(half[3]), 0);
        check("t5_half4", int'(half[4]), 0);
        t3 = -1;
        t4 = -1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (tick[3] && t3 < 0) t3 = k;
            if (tick[4] && t4 < 0) t4 = k;
        end
        check("t5_first3", t3, 4);
        check("t5_first4", t4, 7);
        wait_tick(3, 8, n);
        step(3);
        sync = 1'b1;
        step(1);
        sync = 1'b0;
        check("t5_sync_kills_tick", int'(tick[3]), 0);
        check("t5_sync_half", int'(half[3]), 0);

        // 6: free counter wrap, then reset with a write pending
        n = 0;
        while (free_cnt != 4'd15 && n < 20) begin
            step(1);
            n++;
        end
        check("t6_reach15", int'(free_cnt), 15);
        step(1);
        check("t6_wrap0", int'(free_cnt), 0);
        write_div(1, 2);
        check("t6_pend_before", int'(div_pend[1]), 1);
        rst = 1'b1;
        #1;
        check("t6_rst_pend", int'(div_pend), 0);
        check("t6_rst_outs", int'({div_ack, tick, half, free_cnt}), 0);
        @(negedge clk);
        rst = 1'b0;
        wait_tick(1, 4, n);
        check("t6_div_reset_first", n, 1);
        wait_tick(1, 4, n);
        check("t6_div_reset_every", n, 1);
        step(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
